// File: rtl/matrix_vector_mac_if.sv
// Bus between the weight RAM / requester side and the matrix-vector MAC.
// The master drives start, x and the RAM column word; the slave returns address, status and y.
interface matrix_vector_mac_if #(
  parameter int NROW          = 16,
  parameter int NCOL          = 16,
  parameter int BITWIDTH      = 18,
  parameter int ADDR_BITWIDTH = 4
);
  logic                         start;
  logic [BITWIDTH*NCOL-1:0]     inputVector;
  logic [BITWIDTH*NROW-1:0]     weightColumn;
  logic [ADDR_BITWIDTH-1:0]     address;
  logic                         busy;
  logic                         done;
  logic [BITWIDTH*NROW-1:0]     result;

  modport master (
    output start, inputVector, weightColumn,
    input  address, busy, done, result
  );

  modport slave (
    input  start, inputVector, weightColumn,
    output address, busy, done, result
  );
endinterface

// File: rtl/matrix_vector_mac.sv
// y = W*x for one RNN gate: sweeps RAM columns, accumulates signed fixed-point products, saturates.
// Start accepted at T0; done pulses after edge T(NCOL+2); start is ignored while busy (no backpressure).
module matrix_vector_mac #(
  parameter int NROW          = 16,
  parameter int NCOL          = 16,
  parameter int BITWIDTH      = 18,
  parameter int FRAC_BITS     = 8,
  parameter int ADDR_BITWIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  matrix_vector_mac_if.slave bus
);

  localparam int PROD_W = 2 * BITWIDTH;
  localparam int ACC_W  = PROD_W + $clog2(NCOL);
  localparam logic [ADDR_BITWIDTH-1:0] LAST_ADDR = ADDR_BITWIDTH'(NCOL - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W - BITWIDTH + 1){1'b0}}, {(BITWIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W - BITWIDTH + 1){1'b1}}, {(BITWIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

  state_t                     state, next_state;
  logic                       accept, finish, last_col;
  logic [ADDR_BITWIDTH-1:0]   col_cnt;
  logic [ADDR_BITWIDTH-1:0]   col_d;
  logic                       mac_vld;
  logic signed [BITWIDTH-1:0] x_mem [NCOL];
  logic signed [ACC_W-1:0]    acc   [NROW];
  logic signed [PROD_W-1:0]   prod  [NROW];
  logic signed [ACC_W-1:0]    shifted;
  logic [NROW*BITWIDTH-1:0]   sat_vec;

  assign last_col = (bus.address == LAST_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN:     if (last_col) next_state = DRAIN;
      DRAIN:   next_state = FINISH;
      FINISH: begin
        finish     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The RAM output lags the address by one edge, so x is indexed by the delayed column.
  always_comb begin
    for (int i = 0; i < NROW; i++)
      prod[i] = $signed(bus.weightColumn[i*BITWIDTH +: BITWIDTH]) * x_mem[col_d];
  end

  always_comb begin
    sat_vec = '0;
    shifted = '0;
    for (int i = 0; i < NROW; i++) begin
      shifted = acc[i] >>> FRAC_BITS;
      if (shifted > SAT_MAX)
        sat_vec[i*BITWIDTH +: BITWIDTH] = {1'b0, {(BITWIDTH - 1){1'b1}}};
      else if (shifted < SAT_MIN)
        sat_vec[i*BITWIDTH +: BITWIDTH] = {1'b1, {(BITWIDTH - 1){1'b0}}};
      else
        sat_vec[i*BITWIDTH +: BITWIDTH] = shifted[BITWIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.address <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.result  <= '0;
      col_cnt     <= '0;
      col_d       <= '0;
      mac_vld     <= 1'b0;
      for (int j = 0; j < NCOL; j++) x_mem[j] <= '0;
      for (int i = 0; i < NROW; i++) acc[i] <= '0;
    end else begin
      bus.done <= 1'b0;
      mac_vld  <= (state == RUN);
      col_d    <= bus.address;

      if (accept) begin
        for (int j = 0; j < NCOL; j++) x_mem[j] <= bus.inputVector[j*BITWIDTH +: BITWIDTH];
        for (int i = 0; i < NROW; i++) acc[i] <= '0;
        bus.address <= '0;
        col_cnt     <= ADDR_BITWIDTH'(1);
        bus.busy    <= 1'b1;
      end else begin
        if (state == RUN && !last_col) begin
          bus.address <= col_cnt;
          col_cnt     <= col_cnt + ADDR_BITWIDTH'(1);
        end
        if (mac_vld) begin
          for (int i = 0; i < NROW; i++) acc[i] <= acc[i] + ACC_W'(prod[i]);
        end
      end

      if (finish) begin
        bus.result  <= sat_vec;
        bus.done    <= 1'b1;
        bus.busy    <= 1'b0;
        bus.address <= '0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_vector_mac.sv
// Bench for matrix_vector_mac: two instances (FRAC_BITS 0 and 8) fed by registered weight RAM models.
module tb_matrix_vector_mac;
  localparam int N  = 4;
  localparam int BW = 18;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic reset;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   w0 [N][N];
  int   w8 [N][N];

  always #5 clk = ~clk;

  matrix_vector_mac_if #(.NROW(N), .NCOL(N), .BITWIDTH(BW), .ADDR_BITWIDTH(AW)) if0 ();
  matrix_vector_mac_if #(.NROW(N), .NCOL(N), .BITWIDTH(BW), .ADDR_BITWIDTH(AW)) if8 ();

  matrix_vector_mac #(.NROW(N), .NCOL(N), .BITWIDTH(BW), .FRAC_BITS(0), .ADDR_BITWIDTH(AW))
    u_dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  matrix_vector_mac #(.NROW(N), .NCOL(N), .BITWIDTH(BW), .FRAC_BITS(8), .ADDR_BITWIDTH(AW))
    u_dut8 (.clk(clk), .reset(reset), .bus(if8.slave));

  // Weight RAMs with a registered read port
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if0.weightColumn[i*BW +: BW] <= BW'(w0[i][if0.address]);
      if8.weightColumn[i*BW +: BW] <= BW'(w8[i][if8.address]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [71:0] pack4(input int a, input int b, input int c, input int d);
    logic [71:0] v;
    v = {BW'(d), BW'(c), BW'(b), BW'(a)};
    return v;
  endfunction

  // y[i] = clamp(floor(sum_j W[i][j]*x[j] / 2**frac))
  function automatic logic [71:0] model(input bit s8, input logic [71:0] xv);
    logic [71:0] r;
    longint      sum;
    int          xj;
    r = '0;
    for (int i = 0; i < N; i++) begin
      sum = 0;
      for (int j = 0; j < N; j++) begin
        xj  = int'($signed(xv[j*BW +: BW]));
        sum += longint'(s8 ? w8[i][j] : w0[i][j]) * longint'(xj);
      end
      sum = sum >>> (s8 ? 8 : 0);
      if (sum > 131071)       sum = 131071;
      else if (sum < -131072) sum = -131072;
      r[i*BW +: BW] = sum[BW-1:0];
    end
    return r;
  endfunction

  function automatic int rnd18();
    if ($urandom_range(1, 0) == 1) return int'($urandom_range(600, 0)) - 300;
    return int'($urandom_range(262143, 0)) - 131072;
  endfunction

  task automatic drive(input bit s8, input logic st, input logic [71:0] xv);
    if (s8) begin
      if8.start = st;
      if8.inputVector = xv;
    end else begin
      if0.start = st;
      if0.inputVector = xv;
    end
  endtask

  function automatic logic get_done(input bit s8);
    return s8 ? if8.done : if0.done;
  endfunction

  task automatic wait_done(input bit s8, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!get_done(s8) && n < 40);
  endtask

  task automatic run_check(input bit s8, input logic [71:0] xv, input string tag);
    logic [71:0] exp;
    int          n;
    exp = model(s8, xv);
    drive(s8, 1'b1, xv);
    tick();
    drive(s8, 1'b0, xv);
    wait_done(s8, n);
    check({tag, "_latency"}, 72'(n), 72'(N + 2));
    check({tag, "_result"}, s8 ? if8.result : if0.result, exp);
    check({tag, "_addr"}, s8 ? if8.address : if0.address, 0);
    check({tag, "_busy"}, s8 ? if8.busy : if0.busy, 0);
    tick();
    check({tag, "_done_low"}, get_done(s8), 0);
  endtask

  initial begin
    logic [71:0] xa, xb, ones;
    int          n;
    reset = 1'b1;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        w0[i][j] = 4 * i + j;
        w8[i][j] = 256;
      end
    ones = pack4(1, 1, 1, 1);

    repeat (2) tick();
    check("rst_addr", if0.address, 0);
    check("rst_busy", if0.busy, 0);
    check("rst_done", if0.done, 0);
    check("rst_result", if0.result, 0);
    reset = 1'b0;
    tick();

    // Detailed timing of a single run
    drive(0, 1'b1, ones);
    tick();
    drive(0, 1'b0, ones);
    check("t1_addr0", if0.address, 0);
    check("t1_busy", if0.busy, 1);
    for (int k = 1; k < N; k++) begin
      tick();
      check("t1_addr_seq", if0.address, 72'(k));
      check("t1_done_early", if0.done, 0);
    end
    tick();
    check("t1_addr_hold", if0.address, 72'(N - 1));
    tick();
    check("t1_done_t5", if0.done, 0);
    tick();
    check("t1_done_t6", if0.done, 1);
    check("t1_result_model", if0.result, model(0, ones));
    check("t1_result_const", if0.result, pack4(6, 22, 38, 54));
    check("t1_addr_back", if0.address, 0);
    check("t1_busy_low", if0.busy, 0);
    tick();
    check("t1_done_pulse", if0.done, 0);
    check("t1_result_held", if0.result, pack4(6, 22, 38, 54));

    run_check(0, pack4(1, 0, 0, 0), "t2");
    check("t2_const", if0.result, pack4(0, 4, 8, 12));

    run_check(0, pack4(131071, 131071, 131071, 131071), "t3_pos");
    check("t3_pos_const", if0.result, pack4(131071, 131071, 131071, 131071));
    run_check(0, pack4(-131072, -131072, -131072, -131072), "t3_neg");
    check("t3_neg_const", if0.result, pack4(-131072, -131072, -131072, -131072));

    // start held high, x changed mid-run, then back-to-back accept in the done cycle
    xa = pack4(3, -2, 5, 7);
    xb = pack4(-1, 4, 0, 9);
    drive(0, 1'b1, xa);
    tick();
    repeat (2) tick();
    if0.inputVector = xb;
    wait_done(0, n);
    check("t4_done", if0.done, 1);
    check("t4_result_first", if0.result, model(0, xa));
    tick();
    check("t4_b2b_busy", if0.busy, 1);
    check("t4_b2b_addr", if0.address, 0);
    drive(0, 1'b0, xb);
    wait_done(0, n);
    check("t4_b2b_latency", 72'(n), 72'(N + 2));
    check("t4_result_second", if0.result, model(0, xb));
    tick();

    // Reset in the middle of RUN
    drive(0, 1'b1, ones);
    tick();
    drive(0, 1'b0, ones);
    repeat (2) tick();
    check("t5_pre_addr", if0.address, 2);
    #2;
    reset = 1'b1;
    #1;
    check("t5_addr", if0.address, 0);
    check("t5_busy", if0.busy, 0);
    check("t5_done", if0.done, 0);
    check("t5_result", if0.result, 0);
    tick();
    reset = 1'b0;
    tick();
    check("t5_no_done", if0.done, 0);
    run_check(0, pack4(2, 3, 4, 5), "t5_after");

    // Fixed point with 8 fraction bits
    run_check(1, pack4(128, 128, 128, -1), "t6");
    check("t6_const", if8.result, pack4(383, 383, 383, 383));

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          w0[i][j] = rnd18();
          w8[i][j] = rnd18();
        end
      run_check(0, pack4(rnd18(), rnd18(), rnd18(), rnd18()), "rand_f0");
      run_check(1, pack4(rnd18(), rnd18(), rnd18(), rnd18()), "rand_f8");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
